// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - display-driver bus: MMIO-side inputs and pin-side outputs
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS      = 4,
  parameter int BRIGHTNESS_BITS = 3
);
  logic [4*NUM_DIGITS-1:0]    data;
  logic [NUM_DIGITS-1:0]      decimalPoints;
  logic                       blankLeadingZeros;
  logic [BRIGHTNESS_BITS-1:0] brightness;
  logic                       enable;
  logic [7:0]                 segment;
  logic [NUM_DIGITS-1:0]      digit;
  logic                       frameStart;

  modport master (
    output data, decimalPoints, blankLeadingZeros, brightness, enable,
    input  segment, digit, frameStart
  );

  modport slave (
    input  data, decimalPoints, blankLeadingZeros, brightness, enable,
    output segment, digit, frameStart
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed 7-segment scanner with tear-free frame latching,
// leading-zero blanking, decimal points, PWM brightness and pin polarity control
module seven_seg_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int TICKS_PER_DIGIT  = 131072,
  parameter int BRIGHTNESS_BITS  = 3,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                 clock,
  input  logic                 notReset,
  seven_seg_scanner_if.slave   bus
);

  localparam int TW   = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP = TICKS_PER_DIGIT >> BRIGHTNESS_BITS;
  localparam logic [TW-1:0] LAST_TICK  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

  logic [TW-1:0]           tick_count;
  logic [DW-1:0]           digit_index;
  logic                    primed;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    shadow_blank;
  logic                    frame_start;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   dig_q;

  logic                    tick_wrap;
  logic                    frame_edge;
  logic [3:0]              nibble;
  logic                    dp_bit;
  logic                    blank_cur;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [6:0]              glyph;
  logic [TW:0]             on_ticks;
  logic                    lit;
  logic [7:0]              seg_d;
  logic [NUM_DIGITS-1:0]   dig_d;

  assign tick_wrap  = (tick_count == LAST_TICK);
  assign frame_edge = primed || (tick_wrap && digit_index == LAST_DIGIT);

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      tick_count  <= '0;
      digit_index <= '0;
    end else if (tick_wrap) begin
      tick_count  <= '0;
      digit_index <= (digit_index == LAST_DIGIT) ? '0 : digit_index + 1'b1;
    end else begin
      tick_count  <= tick_count + 1'b1;
    end
  end

  // Shadow copies only change at a frame boundary so a frame is never torn.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      primed       <= 1'b1;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      if (frame_edge) begin
        primed       <= 1'b0;
        shadow_data  <= bus.data;
        shadow_dp    <= bus.decimalPoints;
        shadow_blank <= bus.blankLeadingZeros;
      end
    end
  end

  always_comb begin
    nibble    = 4'h0;
    dp_bit    = 1'b0;
    blank_cur = 1'b0;
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      all_zero     = all_zero && (shadow_data[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      lead_zero[k] = shadow_blank && all_zero && (k != NUM_DIGITS - 1);
      if (DW'(k) == digit_index) begin
        nibble    = shadow_data[4*(NUM_DIGITS-1-k) +: 4];
        dp_bit    = shadow_dp[k];
        blank_cur = lead_zero[k];
      end
    end
  end

  always_comb begin
    glyph = 7'h00;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
  end

  // Nothing is shown before the first shadow load; segments go dark with the digits.
  always_comb begin
    on_ticks = (TW+1)'((32'(bus.brightness) + 32'd1) * 32'(STEP));
    lit      = bus.enable && !primed && ({1'b0, tick_count} < on_ticks);
    seg_d    = '0;
    dig_d    = '0;
    if (lit) begin
      seg_d = {dp_bit, blank_cur ? 7'h00 : glyph};
      dig_d = NUM_DIGITS'(1) << digit_index;
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      seg_q <= '0;
      dig_q <= '0;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign bus.segment    = SEG_ACTIVE_LOW   ? ~seg_q : seg_q;
  assign bus.digit      = DIGIT_ACTIVE_LOW ? ~dig_q : dig_q;
  assign bus.frameStart = frame_start;

endmodule
